// File: rtl/color_uart_reporter.sv
// rtl/color_uart_reporter.sv - turns detected color codes into 3-byte UART 8N1 reports
// Ports:
//   clk_3125     in   UART clock, all logic on rising edge
//   rst_n        in   asynchronous active-low reset
//   color[1:0]   in   color code (1=red, 2=green, 3=blue, 0=none)
//   color_valid  in   one-cycle strobe qualifying color
//   tx           out  UART serial line, idle high
//   busy         out  high while a report is being shifted out
//   pending      out  high while a report is buffered behind the current one
//   frames_sent  out  completed report count, wraps 255->0
module color_uart_reporter #(
  parameter int         CLKS_PER_BIT = 1,
  parameter logic [7:0] MSG_PREFIX   = 8'h43
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic [1:0] color,
  input  logic       color_valid,
  output logic       tx,
  output logic       busy,
  output logic       pending,
  output logic [7:0] frames_sent
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    letter;
  logic [7:0]    hold_letter;

  logic          strobe;
  logic [7:0]    color_letter;
  logic [7:0]    cur_byte;
  logic          baud_done;
  logic          last_byte;
  logic          report_done;
  logic          tx_nx;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    strobe       = color_valid && (color != 2'd0);
    color_letter = 8'h00;
    case (color)
      2'd1:    color_letter = 8'h52;
      2'd2:    color_letter = 8'h47;
      2'd3:    color_letter = 8'h42;
      default: color_letter = 8'h00;
    endcase

    cur_byte = MSG_PREFIX;
    case (byte_idx)
      2'd1:    cur_byte = letter;
      2'd2:    cur_byte = 8'h0A;
      default: cur_byte = MSG_PREFIX;
    endcase

    baud_done   = (baud_cnt == BAUD_LAST);
    last_byte   = (byte_idx == 2'd2);
    report_done = (state == STOP) && baud_done && last_byte;

    state_nx = state;
    tx_nx    = 1'b1;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (strobe) state_nx = START;
      end
      START: begin
        tx_nx = 1'b0;
        if (baud_done) state_nx = DATA;
      end
      DATA: begin
        tx_nx = cur_byte[bit_idx];
        if (baud_done && bit_idx == 3'd7) state_nx = STOP;
      end
      STOP: begin
        tx_nx = 1'b1;
        if (baud_done) begin
          if (!last_byte)           state_nx = START;
          else if (strobe || pending) state_nx = START;
          else                      state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx and busy are registered from the current state, so the line lags the
  // FSM by one cycle; this keeps inputs off any combinational path to outputs.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      byte_idx    <= 2'd0;
      letter      <= 8'h00;
      hold_letter <= 8'h00;
      pending     <= 1'b0;
      frames_sent <= 8'd0;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      tx   <= tx_nx;
      busy <= (state != IDLE);

      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      if (state != DATA)  bit_idx <= 3'd0;
      else if (baud_done) bit_idx <= bit_idx + 3'd1;

      if (state == IDLE)                   byte_idx <= 2'd0;
      else if (state == STOP && baud_done) byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;

      // A strobe landing on the report-done edge beats the buffered letter.
      if (state == IDLE && strobe) begin
        letter <= color_letter;
      end else if (report_done) begin
        if (strobe)       letter <= color_letter;
        else if (pending) letter <= hold_letter;
      end

      if (report_done) begin
        pending     <= 1'b0;
        hold_letter <= 8'h00;
        frames_sent <= frames_sent + 8'd1;
      end else if (strobe && state != IDLE) begin
        pending     <= 1'b1;
        hold_letter <= color_letter;
      end
    end
  end

endmodule

// File: tb/tb_color_uart_reporter.sv
// tb/tb_color_uart_reporter.sv - directed checks of color_uart_reporter at 1 and 4 clocks per bit
module tb_color_uart_reporter;

  logic       clk;
  logic       rst_n;
  logic [1:0] color1, color4;
  logic       valid1, valid4;
  logic       tx1, busy1, pending1;
  logic       tx4, busy4, pending4;
  logic [7:0] frames1, frames4;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  color_uart_reporter #(.CLKS_PER_BIT(1), .MSG_PREFIX(8'h43)) dut1 (
    .clk_3125(clk), .rst_n(rst_n), .color(color1), .color_valid(valid1),
    .tx(tx1), .busy(busy1), .pending(pending1), .frames_sent(frames1)
  );

  color_uart_reporter #(.CLKS_PER_BIT(4), .MSG_PREFIX(8'h43)) dut4 (
    .clk_3125(clk), .rst_n(rst_n), .color(color4), .color_valid(valid4),
    .tx(tx4), .busy(busy4), .pending(pending4), .frames_sent(frames4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe1(input logic [1:0] c);
    color1 = c; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
  endtask

  task automatic strobe4(input logic [1:0] c);
    color4 = c; valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
  endtask

  // Serial order, first bit in the MSB: start, 8 data LSB first, stop, x3.
  function automatic logic [29:0] frame(input logic [7:0] l);
    logic [29:0] f;
    logic [7:0]  b;
    f = '0;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h43 : (k == 1) ? l : 8'h0A;
      f = {f[28:0], 1'b0};
      for (int j = 0; j < 8; j++) f = {f[28:0], b[j]};
      f = {f[28:0], 1'b1};
    end
    return f;
  endfunction

  function automatic logic [119:0] expand4(input logic [29:0] f);
    logic [119:0] e;
    e = '0;
    for (int k = 29; k >= 0; k--)
      for (int r = 0; r < 4; r++) e = {e[118:0], f[k]};
    return e;
  endfunction

  logic [29:0]  b30;
  logic [59:0]  b60;
  logic [119:0] b120;
  int           bc;

  initial begin
    rst_n = 1'b0;
    color1 = 2'd0; valid1 = 1'b0;
    color4 = 2'd0; valid4 = 1'b0;
    tick(); tick();
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_pending1", pending1, 0);
    chk("rst_frames1", frames1, 0);
    chk("rst_tx4", tx4, 1);
    chk("rst_frames4", frames4, 0);
    rst_n = 1'b1;
    tick();

    // Single red report.
    strobe1(2'd1);
    chk("strobe_edge_busy", busy1, 0);
    b30 = '0; bc = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      b30 = {b30[28:0], tx1};
      if (busy1) bc++;
    end
    chk("red_frame", b30, 30'b0_11000010_1_0_01001010_1_0_01010000_1);
    chk("red_busy_cycles", bc, 30);
    tick();
    chk("red_idle_busy", busy1, 0);
    chk("red_frames", frames1, 1);

    // Color 0 in idle does nothing.
    strobe1(2'd0);
    tick();
    chk("zero_idle_busy", busy1, 0);
    chk("zero_idle_tx", tx1, 1);
    chk("zero_idle_frames", frames1, 1);

    // Blue, then green buffered at cycle 5, color 0 while pending.
    strobe1(2'd3);
    b60 = '0; bc = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5)  begin color1 = 2'd2; valid1 = 1'b1; end
      if (i == 10) begin color1 = 2'd0; valid1 = 1'b1; end
      tick();
      valid1 = 1'b0;
      b60 = {b60[58:0], tx1};
      if (busy1) bc++;
      if (i == 5)  chk("bg_pending_set", pending1, 1);
      if (i == 10) chk("bg_zero_keeps_pending", pending1, 1);
      if (i == 31) chk("bg_pending_cleared", pending1, 0);
    end
    chk("bg_frames_stream", b60, {frame(8'h42), frame(8'h47)});
    chk("bg_busy_cycles", bc, 60);
    tick();
    chk("bg_idle_busy", busy1, 0);
    chk("bg_frames", frames1, 3);

    // Latest buffered letter wins: red then blue while busy.
    strobe1(2'd2);
    b60 = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 3) begin color1 = 2'd1; valid1 = 1'b1; end
      if (i == 7) begin color1 = 2'd3; valid1 = 1'b1; end
      tick();
      valid1 = 1'b0;
      b60 = {b60[58:0], tx1};
    end
    chk("overwrite_stream", b60, {frame(8'h47), frame(8'h42)});
    bc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy1 || !tx1) bc++;
    end
    chk("overwrite_no_third", bc, 0);
    chk("overwrite_frames", frames1, 5);

    // Strobe on the report-done edge beats the buffered green.
    strobe1(2'd1);
    b60 = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 3)  begin color1 = 2'd2; valid1 = 1'b1; end
      if (i == 30) begin color1 = 2'd3; valid1 = 1'b1; end
      tick();
      valid1 = 1'b0;
      b60 = {b60[58:0], tx1};
      if (i == 30) chk("sameedge_pending", pending1, 0);
    end
    chk("sameedge_stream", b60, {frame(8'h52), frame(8'h42)});
    tick();
    chk("sameedge_idle", busy1, 0);
    chk("sameedge_frames", frames1, 7);

    // Reset during DATA of byte 1.
    strobe1(2'd1);
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin color1 = 2'd2; valid1 = 1'b1; end
      tick();
      valid1 = 1'b0;
    end
    chk("pre_rst_tx", tx1, 0);
    chk("pre_rst_pending", pending1, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_pending", pending1, 0);
    chk("midrst_frames", frames1, 0);
    #2;
    rst_n = 1'b1;
    tick();
    strobe1(2'd2);
    b30 = '0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      b30 = {b30[28:0], tx1};
    end
    chk("post_rst_frame", b30, frame(8'h47));
    tick();
    chk("post_rst_frames", frames1, 1);

    // Four clocks per bit.
    strobe4(2'd2);
    b120 = '0; bc = 0;
    for (int i = 1; i <= 120; i++) begin
      tick();
      b120 = {b120[118:0], tx4};
      if (busy4) bc++;
    end
    chk("cpb4_frame", b120, expand4(frame(8'h47)));
    chk("cpb4_busy_cycles", bc, 120);
    tick();
    chk("cpb4_idle", busy4, 0);
    chk("cpb4_frames", frames4, 1);
    for (int r = 2; r <= 255; r++) begin
      strobe4(2'd2);
      repeat (121) tick();
    end
    chk("cpb4_frames_255", frames4, 255);
    strobe4(2'd2);
    repeat (121) tick();
    chk("cpb4_frames_wrap", frames4, 0);
    chk("cpb4_final_tx", tx4, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
